viterbi_acs_traceback: RTL and testbench

Hard-decision Viterbi decoding core for the rate-1/2, K=3 convolutional code (generators 7,5 octal). Sits directly downstream of the 16-to-2 parallel-in/serial-out stage. It consumes one received 2-bit code symbol per valid cycle and runs add-compare-select over 4 trellis states, storing survivor decisions. At block end it traces back and emits the decoded message word with its final path metric.

---
 rtl/viterbi_acs_traceback.sv | 191 +++++++++++++++++++
 tb/tb_viterbi_acs_traceback.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/viterbi_acs_traceback.sv
// viterbi_acs_traceback
//   Hard-decision Viterbi decoder for the rate-1/2, K=3 (7,5 octal) code.
//   One received symbol per valid cycle runs add-compare-select over the
//   four trellis states and stores the four decision bits. At block end the
//   survivor memory is traced back and the decoded word is emitted together
//   with the winning path metric.
//
// Ports
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_data[1:0]       received symbol {c0 (G=111), c1 (G=101)}
//   i_valid, i_last   symbol strobe / final symbol of block
//   o_data[N-1:0]     decoded bits, first symbol at MSB
//   o_metric          winning path metric (Hamming errors)
//   o_valid           one-cycle result strobe
//   o_busy            high while symbols are not accepted

// One trellis node: picks the cheaper of the two predecessors {n[0],0} and
// {n[0],1}. The expected branch symbols are fixed by the node index, so they
// fold into constants.
module viterbi_acs_traceback_node #(
  parameter int         METRIC_W = 6,
  parameter logic [1:0] NODE     = 2'd0
) (
  input  logic [1:0]          sym_i,
  input  logic [METRIC_W-1:0] pm_p0_i,
  input  logic [METRIC_W-1:0] pm_p1_i,
  output logic [METRIC_W-1:0] pm_o,
  output logic                dec_o
);
  localparam logic       U  = NODE[1];
  localparam logic [1:0] P0 = {NODE[0], 1'b0};
  localparam logic [1:0] P1 = {NODE[0], 1'b1};
  localparam logic [1:0] E0 = {U ^ P0[1] ^ P0[0], U ^ P0[0]};
  localparam logic [1:0] E1 = {U ^ P1[1] ^ P1[0], U ^ P1[0]};

  function automatic logic [1:0] hd(input logic [1:0] a, input logic [1:0] b);
    hd = {1'b0, a[1] ^ b[1]} + {1'b0, a[0] ^ b[0]};
  endfunction

  logic [METRIC_W-1:0] sum0, sum1;

  assign sum0  = pm_p0_i + METRIC_W'(hd(sym_i, E0));
  assign sum1  = pm_p1_i + METRIC_W'(hd(sym_i, E1));
  // strict compare: ties keep predecessor {n[0],0}
  assign dec_o = (sum1 < sum0);
  assign pm_o  = dec_o ? sum1 : sum0;
endmodule

module viterbi_acs_traceback #(
  parameter int NUM_SYMBOLS = 8,
  parameter int METRIC_W    = 6
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [1:0]             i_data,
  input  logic                   i_valid,
  input  logic                   i_last,
  output logic [NUM_SYMBOLS-1:0] o_data,
  output logic [METRIC_W-1:0]    o_metric,
  output logic                   o_valid,
  output logic                   o_busy
);
  localparam int CNT_W = $clog2(NUM_SYMBOLS + 1);
  localparam int IDX_W = $clog2(NUM_SYMBOLS);

  // state 0 is the known encoder start state; the others start penalised
  localparam logic [3:0][METRIC_W-1:0] PM_INIT =
    {METRIC_W'(8), METRIC_W'(8), METRIC_W'(8), METRIC_W'(0)};

  typedef enum logic [1:0] {ACCEPT, TRACE, OUT} state_t;

  state_t                           state_q, state_d;
  logic [3:0][METRIC_W-1:0]         pm_q, pm_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic [NUM_SYMBOLS-1:0][3:0]      surv_q, surv_d;
  logic                             first_q, first_d;
  logic [1:0]                       st_q, st_d;
  logic [IDX_W-1:0]                 k_q, k_d;
  logic [NUM_SYMBOLS-1:0]           dec_q, dec_d;
  logic [METRIC_W-1:0]              metric_q, metric_d;
  logic [NUM_SYMBOLS-1:0]           odata_q, odata_d;
  logic [METRIC_W-1:0]              ometric_q, ometric_d;

  logic [3:0][METRIC_W-1:0]         pm_new;
  logic [3:0]                       dec_new;
  logic [1:0]                       best;

  for (genvar n = 0; n < 4; n++) begin : g_node
    localparam logic [1:0] NN = 2'(n);
    viterbi_acs_traceback_node #(.METRIC_W(METRIC_W), .NODE(NN)) u_node (
      .sym_i   (i_data),
      .pm_p0_i (pm_q[{NN[0], 1'b0}]),
      .pm_p1_i (pm_q[{NN[0], 1'b1}]),
      .pm_o    (pm_new[n]),
      .dec_o   (dec_new[n])
    );
  end

  // traceback start: smallest metric, lowest index on ties
  always_comb begin
    best = 2'd0;
    for (int i = 1; i < 4; i++)
      if (pm_q[i] < pm_q[best]) best = 2'(i);
  end

  always_comb begin
    state_d   = state_q;
    pm_d      = pm_q;
    cnt_d     = cnt_q;
    surv_d    = surv_q;
    first_d   = first_q;
    st_d      = st_q;
    k_d       = k_q;
    dec_d     = dec_q;
    metric_d  = metric_q;
    odata_d   = odata_q;
    ometric_d = ometric_q;
    case (state_q)
      ACCEPT: begin
        if (i_valid) begin
          pm_d                        = pm_new;
          surv_d[cnt_q[IDX_W-1:0]]    = dec_new;
          cnt_d                       = cnt_q + CNT_W'(1);
          if (i_last || cnt_q == CNT_W'(NUM_SYMBOLS - 1)) begin
            state_d = TRACE;
            first_d = 1'b1;
          end
        end
      end
      TRACE: begin
        if (first_q) begin
          first_d  = 1'b0;
          st_d     = best;
          metric_d = pm_q[best];
          k_d      = IDX_W'(cnt_q - CNT_W'(1));
          dec_d    = '0;  // unused LSBs of a short block stay 0
        end else begin
          // state after symbol k holds u[k] in its MSB
          dec_d[IDX_W'(NUM_SYMBOLS - 1) - k_q] = st_q[1];
          st_d = {st_q[0], surv_q[k_q][st_q]};
          if (k_q == '0) begin
            state_d   = OUT;
            odata_d   = dec_d;
            ometric_d = metric_q;
          end else begin
            k_d = k_q - IDX_W'(1);
          end
        end
      end
      OUT: begin
        state_d = ACCEPT;
        pm_d    = PM_INIT;
        cnt_d   = '0;
      end
      default: state_d = ACCEPT;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ACCEPT;
      pm_q      <= PM_INIT;
      cnt_q     <= '0;
      surv_q    <= '0;
      first_q   <= 1'b0;
      st_q      <= '0;
      k_q       <= '0;
      dec_q     <= '0;
      metric_q  <= '0;
      odata_q   <= '0;
      ometric_q <= '0;
    end else begin
      state_q   <= state_d;
      pm_q      <= pm_d;
      cnt_q     <= cnt_d;
      surv_q    <= surv_d;
      first_q   <= first_d;
      st_q      <= st_d;
      k_q       <= k_d;
      dec_q     <= dec_d;
      metric_q  <= metric_d;
      odata_q   <= odata_d;
      ometric_q <= ometric_d;
    end
  end

  assign o_data   = odata_q;
  assign o_metric = ometric_q;
  assign o_valid  = (state_q == OUT);
  assign o_busy   = (state_q != ACCEPT);
endmodule

// File: tb/tb_viterbi_acs_traceback.sv
module tb_viterbi_acs_traceback;
  localparam int NS = 8;
  localparam int MW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    data;
  logic          valid, last;
  logic [NS-1:0] od;
  logic [MW-1:0] om;
  logic          ov, ob;

  viterbi_acs_traceback #(.NUM_SYMBOLS(NS), .METRIC_W(MW)) dut (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid), .i_last(last),
    .o_data(od), .o_metric(om), .o_valid(ov), .o_busy(ob)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] d; int m; int lat; int edge_n; } exp_t;
  typedef struct { logic [15:0] w; int n; logic [7:0] d; int m; } vec_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // result monitor: every o_valid pulse must match the oldest expectation
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (ov === 1'b1) begin
      if (sb.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL spurious_valid: o_valid pulsed with no block pending, o_data=0x%0h", od);
      end else begin
        e = sb.pop_front();
        chk("o_data", od, e.d);
        chk("o_metric", om, e.m);
        chk("valid_latency", cyc - e.edge_n, e.lat);
      end
    end
  end

  // symbols from MSB pairs of w; returns just after the edge sampling the last
  task automatic drive_syms(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      data  = w[15-2*i -: 2];
      valid = 1'b1;
      last  = (i == n - 1);
      @(posedge clk); #1;
    end
  endtask

  task automatic send(input logic [15:0] w, input int n, input logic [7:0] ed,
                      input int em, input bit junk);
    exp_t e;
    int   busy_n;
    drive_syms(w, n);
    e.d = ed; e.m = em; e.lat = n + 1; e.edge_n = cyc;
    sb.push_back(e);
    last = 1'b0;
    if (junk) begin valid = 1'b1; data = 2'b11; end
    else valid = 1'b0;
    busy_n = 0;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (!ob) break;
      busy_n++;
    end
    valid = 1'b0;
    chk("busy_cycles", busy_n, n + 2);
    chk("hold_data", od, ed);
  endtask

  function automatic logic [15:0] encode(input logic [7:0] msg);
    logic [1:0] s;
    logic       u;
    logic [15:0] w;
    s = 2'b00;
    w = '0;
    for (int k = 0; k < 8; k++) begin
      u = msg[7-k];
      w[15-2*k] = u ^ s[1] ^ s[0];
      w[14-2*k] = u ^ s[0];
      s = {u, s[1]};
    end
    return w;
  endfunction

  vec_t tbl[5];

  initial begin
    logic [7:0]  msg;
    logic [15:0] w;
    int          p, em;

    tbl[0] = '{16'hE170, 8, 8'hB0, 0};  // clean block
    tbl[1] = '{16'hE970, 8, 8'hB0, 1};  // one bit error in 3rd symbol
    tbl[2] = '{16'h0000, 8, 8'h00, 0};  // all zero
    tbl[3] = '{16'hE100, 4, 8'hB0, 0};  // early last after 4 symbols
    tbl[4] = '{16'hC000, 1, 8'h80, 0};  // single-symbol block

    rst = 1'b1; data = '0; valid = 1'b0; last = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_o_data", od, 0);
    chk("rst_o_metric", om, 0);
    chk("rst_o_valid", ov, 0);
    chk("rst_o_busy", ob, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) send(tbl[i].w, tbl[i].n, tbl[i].d, tbl[i].m, 1'b0);

    // random messages, optionally one bit flipped outside the last symbol
    for (int r = 0; r < 6; r++) begin
      msg = 8'($urandom);
      w   = encode(msg);
      em  = 0;
      if (r % 2 == 1) begin
        p = $urandom_range(0, 13);
        w[15-p] = ~w[15-p];
        em = 1;
      end
      send(w, 8, msg, em, 1'b0);
    end

    // symbols held valid through TRACE/OUT must be ignored
    send(16'hE170, 8, 8'hB0, 0, 1'b1);
    send(16'hE100, 4, 8'hB0, 0, 1'b0);

    // reset three cycles into TRACE
    drive_syms(16'hE170, 8);
    valid = 1'b0; last = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_o_data", od, 0);
    chk("abort_o_metric", om, 0);
    chk("abort_o_valid", ov, 0);
    chk("abort_o_busy", ob, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (15) @(negedge clk);
    send(16'hE170, 8, 8'hB0, 0, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", nchk, nerr);
    $fatal(1);
  end
endmodule
